// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, 2-flop row sync, press/release debounce.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV      = 24000,
  parameter int unsigned DB_CYCLES     = 480000,
  parameter int unsigned REPEAT_CYCLES = 12000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned MAXP_A = (SCAN_DIV > DB_CYCLES) ? SCAN_DIV : DB_CYCLES;
  localparam int unsigned MAXP   = (MAXP_A > REPEAT_CYCLES) ? MAXP_A : REPEAT_CYCLES;
  localparam int unsigned CW     = $clog2(MAXP + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          r_state, w_state;
  logic [3:0]      r_rows_m, r_rows_s;
  logic [1:0]      r_col, w_col;
  logic [1:0]      r_row, w_row;
  logic [CW-1:0]   r_dwell, w_dwell;
  logic [CW-1:0]   r_db, w_db;
  logic [3:0]      r_code, w_code;
  logic            r_valid, w_valid;
  logic            r_held, w_held;
  logic [1:0]      w_low;
  logic            w_found;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CW-1:0]   r_rep, w_rep;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rows_m <= 4'hF;
      r_rows_s <= 4'hF;
      r_state  <= SCAN;
      r_col    <= '0;
      r_row    <= '0;
      r_dwell  <= '0;
      r_db     <= '0;
      r_code   <= '0;
      r_valid  <= 1'b0;
      r_held   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep    <= '0;
`endif
    end else begin
      r_rows_m <= rows;
      r_rows_s <= r_rows_m;
      r_state  <= w_state;
      r_col    <= w_col;
      r_row    <= w_row;
      r_dwell  <= w_dwell;
      r_db     <= w_db;
      r_code   <= w_code;
      r_valid  <= w_valid;
      r_held   <= w_held;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep    <= w_rep;
`endif
    end
  end

  // Lowest-index active row wins when several rows are low together.
  always_comb begin
    w_low   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!r_rows_s[i] && !w_found) begin
        w_low   = 2'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_col   = r_col;
    w_row   = r_row;
    w_dwell = r_dwell;
    w_db    = r_db;
    w_code  = r_code;
    w_valid = 1'b0;
    w_held  = r_held;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rep   = r_rep;
`endif
    case (r_state)
      SCAN: begin
        if (r_dwell == CW'(SCAN_DIV - 1)) begin
          w_dwell = '0;
          if (r_rows_s == 4'hF) begin
            w_col = r_col + 2'd1;
          end else begin
            w_row   = w_low;
            w_db    = '0;
            w_state = DEBOUNCE;
          end
        end else begin
          w_dwell = r_dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!r_rows_s[r_row]) begin
          if (r_db == CW'(DB_CYCLES - 1)) begin
            w_code  = {r_row, r_col};
            w_valid = 1'b1;
            w_held  = 1'b1;
            w_state = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            w_rep   = '0;
`endif
          end else begin
            w_db = r_db + 1'b1;
          end
        end else begin
          w_db    = '0;
          w_col   = r_col + 2'd1;
          w_dwell = '0;
          w_state = SCAN;
        end
      end
      HELD: begin
        if (r_rows_s[r_row]) begin
          w_db    = '0;
          w_state = RELEASE;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (r_rep == CW'(REPEAT_CYCLES - 1)) begin
          w_rep   = '0;
          w_valid = 1'b1;
        end else begin
          w_rep = r_rep + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (r_rows_s[r_row]) begin
          if (r_db == CW'(DB_CYCLES - 1)) begin
            w_held  = 1'b0;
            w_db    = '0;
            w_col   = r_col + 2'd1;
            w_dwell = '0;
            w_state = SCAN;
          end else begin
            w_db = r_db + 1'b1;
          end
        end else begin
          // A bounce during release returns to HELD without re-announcing the key.
          w_db    = '0;
          w_state = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          w_rep   = '0;
`endif
        end
      end
      default: w_state = SCAN;
    endcase
  end

  assign cols      = ~(4'b0001 << r_col);
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad model driving rows from cols.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows, cols, key_code;
  logic        key_valid, key_held;

  logic [15:0] pressed = '0;
  logic        use_direct = 1'b1;
  logic [3:0]  rows_direct = 4'hF;

  int checks = 0, failures = 0;
  int cyc = 0, vcnt = 0, vlast = 0, vprev = 0;

  keypad_scanner #(.SCAN_DIV(4), .DB_CYCLES(8), .REPEAT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows = 4'hF;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        if (pressed[4*r+c] && !cols[c]) rows[r] = 1'b0;
    if (use_direct) rows = rows_direct;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (key_valid) begin
      vcnt  <= vcnt + 1;
      vprev <= vlast;
      vlast <= cyc;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < maxc) begin
      @(negedge clk);
      n++;
      if (key_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_release(input int maxc, output bit ok, output int n);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < maxc) begin
      @(negedge clk);
      n++;
      if (!key_held) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  exp_code;
    logic [3:0]  exp_cols_held;
    logic [3:0]  exp_cols_after;
  } vec_t;

  vec_t tbl[5];

  initial begin
    bit ok;
    int n, v0, t0;

    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int n, v0, t0;

    tbl[0] = '{16'h0200, 4'd9,  4'b1101, 4'b1011};
    tbl[1] = '{16'h0001, 4'd0,  4'b1110, 4'b1101};
    tbl[2] = '{16'h8000, 4'd15, 4'b0111, 4'b1110};
    tbl[3] = '{16'h0040, 4'd6,  4'b1011, 4'b0111};
    tbl[4] = '{16'h1010, 4'd4,  4'b1110, 4'b1101};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cols",  {12'h0, cols}, 16'hE);
    check("reset_code",  {12'h0, key_code}, 16'h0);
    check("reset_valid", {15'h0, key_valid}, 16'h0);
    check("reset_held",  {15'h0, key_held}, 16'h0);

    // Short press on row1 at col0: aborted debounce, scanning moves on to col1.
    v0 = vcnt;
    reset = 1'b0;
    rows_direct = 4'b1101;
    repeat (5) @(negedge clk);
    rows_direct = 4'hF;
    repeat (2) @(negedge clk);
    check("short_cols_frozen", {12'h0, cols}, 16'hE);
    @(negedge clk);
    check("short_cols_resume", {12'h0, cols}, 16'hD);
    check("short_no_pulse", 16'(vcnt - v0), 16'h0);
    check("short_held", {15'h0, key_held}, 16'h0);
    use_direct = 1'b0;

    for (int i = 0; i < 5; i++) begin
      v0 = vcnt;
      pressed = tbl[i].keys;
      wait_valid(80, ok);
      check($sformatf("v%0d_pulse_seen", i), {15'h0, ok}, 16'h1);
      check($sformatf("v%0d_code", i), {12'h0, key_code}, {12'h0, tbl[i].exp_code});
      check($sformatf("v%0d_held", i), {15'h0, key_held}, 16'h1);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_cols_frozen", i), {12'h0, cols}, {12'h0, tbl[i].exp_cols_held});
      check($sformatf("v%0d_one_pulse", i), 16'(vcnt - v0), 16'h1);
      pressed = '0;
      wait_release(40, ok, n);
      check($sformatf("v%0d_released", i), {15'h0, ok}, 16'h1);
      check($sformatf("v%0d_cols_after", i), {12'h0, cols}, {12'h0, tbl[i].exp_cols_after});
      check($sformatf("v%0d_code_kept", i), {12'h0, key_code}, {12'h0, tbl[i].exp_code});
      @(negedge clk);
      check($sformatf("v%0d_no_release_pulse", i), 16'(vcnt - v0), 16'h1);
    end

    // Release bounce: high 3, low 1, then high until held drops.
    v0 = vcnt;
    pressed = 16'h2000;
    wait_valid(80, ok);
    check("glitch_pulse_seen", {15'h0, ok}, 16'h1);
    check("glitch_code", {12'h0, key_code}, 16'd13);
    use_direct = 1'b1;
    rows_direct = 4'hF;
    repeat (3) @(negedge clk);
    rows_direct = 4'b0111;
    @(negedge clk);
    rows_direct = 4'hF;
    repeat (8) @(negedge clk);
    check("glitch_held_through", {15'h0, key_held}, 16'h1);
    wait_release(10, ok, n);
    check("glitch_released", {15'h0, ok}, 16'h1);
    check("glitch_release_time", 16'(n), 16'd3);
    check("glitch_cols_after", {12'h0, cols}, 16'b1011);
    @(negedge clk);
    check("glitch_one_pulse", 16'(vcnt - v0), 16'h1);
    use_direct = 1'b0;
    pressed = '0;

    // Long hold of key 10 for 50 cycles after acceptance.
    pressed = 16'h0400;
    wait_valid(80, ok);
    check("hold_pulse_seen", {15'h0, ok}, 16'h1);
    @(negedge clk);
    t0 = vlast;
    v0 = vcnt;
    repeat (50) @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold_repeat_count", 16'(vcnt - v0), 16'd2);
    check("hold_repeat_first", 16'(vprev - t0), 16'd20);
    check("hold_repeat_second", 16'(vlast - t0), 16'd40);
`else
    check("hold_repeat_count", 16'(vcnt - v0), 16'd0);
`endif
    check("hold_code", {12'h0, key_code}, 16'd10);
    check("hold_held", {15'h0, key_held}, 16'h1);
    pressed = '0;
    wait_release(40, ok, n);
    check("hold_released", {15'h0, ok}, 16'h1);

    // Reset asserted mid-debounce of key 5.
    pressed = 16'h0020;
    n = 0;
    while (cols != 4'b1101 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("abort_col1_reached", {12'h0, cols}, 16'b1101);
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_cols",  {12'h0, cols}, 16'hE);
    check("abort_valid", {15'h0, key_valid}, 16'h0);
    check("abort_held",  {15'h0, key_held}, 16'h0);
    check("abort_code",  {12'h0, key_code}, 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v0 = vcnt;
    repeat (12) @(negedge clk);
    check("abort_no_early_pulse", 16'(vcnt - v0), 16'h0);
    wait_valid(80, ok);
    check("abort_new_press", {15'h0, ok}, 16'h1);
    check("abort_new_code", {12'h0, key_code}, 16'd5);
    pressed = '0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
